async_traffic_gen: RTL and testbench
====================================

Name: async_traffic_gen

Overview:
- Per-node traffic source for the asynchronous-clock NoC testbench.
- Consumes one bit of the clock generator's per-node clock vector, plus its reset and send outputs.
- Drives packets into the local router injection port with a valid/ready handshake.
- Injection timing and destinations are pseudo-random from an LFSR; accepted packets are counted for throughput checks during the cooldown phase.

Parameters:
- NODE_ID, 0, this node's index; placed in the source field of every head flit.
- NUM_NODES, 9, number of nodes in the network; a destination is valid only if it is < NUM_NODES.
- DEST_BITS, 4, width of the destination and source fields.
- FLIT_W, 32, flit width; must be >= 2*DEST_BITS+16 and >= 32.
- PKT_FLITS, 4, flits per packet; legal range 1..65535.
- RATE, 32, injection threshold out of 256 (9-bit value); 0 = never inject, 256 = inject on every valid draw.
- SEED, 16'hACE1, initial LFSR value; a SEED of 0 is replaced by 16'hACE1.

Ports:
- clk, input, 1, node-local clock.
- reset, input, 1, asynchronous, active-high.
- send, input, 1, injection enable from the clock generator.
- tx_data, output, FLIT_W, current flit.
- tx_valid, output, 1, flit valid.
- tx_ready, input, 1, router accepts the flit.
- tx_head, output, 1, current flit is a head flit.
- tx_tail, output, 1, current flit is a tail flit.
- pkt_count, output, 16, packets fully accepted (tail handshake); saturates at 16'hFFFF.
- busy, output, 1, a packet is in flight (state != IDLE).

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, lfsr = SEED, flit index = 0.
  - Outputs: tx_valid = 0, tx_head = 0, tx_tail = 0, tx_data = 0, pkt_count = 0, busy = 0.
  - Reset asserted mid-packet aborts the packet immediately; no tail is emitted.
- LFSR:
  - 16-bit Galois, advances on every clk edge outside reset.
  - Update: lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
- Draw (each IDLE cycle with send = 1):
  - inject = ({1'b0, lfsr[7:0]} < RATE).
  - dest = lfsr[8+DEST_BITS-1:8].
  - If inject, dest < NUM_NODES, and dest != NODE_ID: latch dest and go to HEAD.
  - Otherwise stay in IDLE. There is no retry bias.
- States:
  - IDLE -> HEAD on a successful draw.
  - HEAD: tx_valid = 1, tx_head = 1. tx_tail = 1 only if PKT_FLITS == 1.
    - On handshake: go to IDLE if PKT_FLITS == 1, else go to BODY with index = 1.
  - BODY: tx_valid = 1, tx_head = 0, tx_tail = (index == PKT_FLITS-1).
    - On handshake: index increments; after the tail handshake, go to IDLE.
- Latency: draw in cycle N -> head flit valid in cycle N+1.
- Packet spacing: after a tail handshake there is at least one IDLE cycle before the next head.
- Flit format:
  - Head: [DEST_BITS-1:0] = dest; [2*DEST_BITS-1:DEST_BITS] = NODE_ID; [2*DEST_BITS+15:2*DEST_BITS] = seq; remaining bits 0.
  - Body: [15:0] = flit index; [31:16] = seq; remaining bits 0.
  - seq = pkt_count value latched at the draw.
- Handshake rules:
  - A flit transfers on a clk edge with tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data, tx_head and tx_tail hold stable.
  - tx_valid never drops without a handshake, except on reset.
- send deasserted mid-packet: the current packet completes; no new draws are made.
- send = 1 while busy: no effect.
- pkt_count increments on the tail handshake and saturates at 16'hFFFF.

Optional Feature:
- Macro: TRAFFIC_STATS_EN.
- Defined:
  - Adds output stall_count [15:0]: +1 per cycle with tx_valid && !tx_ready; saturates at 16'hFFFF; reset to 0.
  - Adds output drop_count [15:0]: +1 per IDLE cycle with send = 1 and inject = 1 but an invalid or self destination; saturates; reset to 0.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- RATE=256, tx_ready=1, PKT_FLITS=4, send held 1 for 100 cycles -> every packet has a 4-flit head..tail run; head dest < 9 and != NODE_ID; source field = NODE_ID; seq increments 0,1,2,...; final pkt_count equals the number of tail handshakes observed.
- RATE=0, send=1 for 1000 cycles -> tx_valid stays 0 and pkt_count = 0.
- RATE=256, tx_ready=0 for 10 cycles after the head is presented -> head flit stable for all 10 cycles; tail appears 3 handshakes after ready returns; with TRAFFIC_STATS_EN, stall_count = 10.
- send drops while the 2nd flit of a packet is valid -> flits 2..4 still delivered, tx_tail on the 4th flit, then tx_valid stays 0 and busy = 0.
- reset asserted asynchronously mid-BODY -> tx_valid, busy and pkt_count are 0 before the next clk edge; the first draw after release uses lfsr = SEED.
- PKT_FLITS=1 -> every flit has tx_head = tx_tail = 1; pkt_count increments once per handshake.

Source files
------------

// File: rtl/async_traffic_gen_if.sv
// Injection-port bundle between a traffic source (master) and a router (slave).
interface async_traffic_gen_if #(
  parameter int FLIT_W = 32
) ();
  logic [FLIT_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_head;
  logic              tx_tail;

  modport master (output tx_data, output tx_valid, output tx_head, output tx_tail, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_head, input tx_tail, output tx_ready);
endinterface

// File: rtl/async_traffic_gen.sv
// Per-node LFSR-driven packet source for the async NoC bench.
// Define TRAFFIC_STATS_EN to add the stall_count/drop_count outputs.
module async_traffic_gen #(
  parameter int          NODE_ID   = 0,
  parameter int          NUM_NODES = 9,
  parameter int          DEST_BITS = 4,
  parameter int          FLIT_W    = 32,
  parameter int          PKT_FLITS = 4,
  parameter int          RATE      = 32,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                send,
  async_traffic_gen_if.master tx,
  output logic [15:0]         pkt_count,
  output logic                busy
`ifdef TRAFFIC_STATS_EN
  ,
  output logic [15:0]         stall_count,
  output logic [15:0]         drop_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(PKT_FLITS - 1);

  logic [1:0]           r_state;
  logic [15:0]          r_lfsr;
  logic [15:0]          r_idx;
  logic [15:0]          r_seq;
  logic [15:0]          r_pkt_count;
  logic [DEST_BITS-1:0] r_dest;

  logic [15:0]          w_lfsr_next;
  logic [DEST_BITS-1:0] w_dest;
  logic                 w_inject;
  logic                 w_dest_ok;
  logic                 w_draw;
  logic                 w_fire;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_inject    = ({1'b0, r_lfsr[7:0]} < 9'(RATE));
  assign w_dest      = r_lfsr[8 +: DEST_BITS];
  assign w_dest_ok   = (32'(w_dest) < 32'(NUM_NODES)) && (32'(w_dest) != 32'(NODE_ID));
  assign w_draw      = (r_state == S_IDLE) && send && w_inject && w_dest_ok;
  assign w_fire      = tx.tx_valid && tx.tx_ready;

  assign pkt_count = r_pkt_count;
  assign busy      = (r_state != S_IDLE);

  // Flit fields are decoded from registered state so they stay stable under backpressure.
  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_head  = 1'b0;
    tx.tx_tail  = 1'b0;
    tx.tx_data  = '0;
    case (r_state)
      S_HEAD: begin
        tx.tx_valid                          = 1'b1;
        tx.tx_head                           = 1'b1;
        tx.tx_tail                           = (PKT_FLITS == 1);
        tx.tx_data[DEST_BITS-1:0]            = r_dest;
        tx.tx_data[DEST_BITS +: DEST_BITS]   = DEST_BITS'(NODE_ID);
        tx.tx_data[2*DEST_BITS +: 16]        = r_seq;
      end
      S_BODY: begin
        tx.tx_valid         = 1'b1;
        tx.tx_tail          = (r_idx == LAST_IDX);
        tx.tx_data[15:0]    = r_idx;
        tx.tx_data[31:16]   = r_seq;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED_EFF;
      r_idx       <= '0;
      r_seq       <= '0;
      r_dest      <= '0;
      r_pkt_count <= '0;
    end else begin
      r_lfsr <= w_lfsr_next;
      case (r_state)
        S_IDLE: begin
          if (w_draw) begin
            r_state <= S_HEAD;
            r_dest  <= w_dest;
            r_seq   <= r_pkt_count;
            r_idx   <= '0;
          end
        end
        S_HEAD: begin
          if (w_fire) begin
            if (PKT_FLITS == 1) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_BODY;
              r_idx   <= 16'd1;
            end
          end
        end
        S_BODY: begin
          if (w_fire) begin
            r_idx <= r_idx + 16'd1;
            if (r_idx == LAST_IDX) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_fire && tx.tx_tail && (r_pkt_count != 16'hFFFF)) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

`ifdef TRAFFIC_STATS_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_drop_count;

  assign stall_count = r_stall_count;
  assign drop_count  = r_drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (tx.tx_valid && !tx.tx_ready && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
      if ((r_state == S_IDLE) && send && w_inject && !w_dest_ok && (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_async_traffic_gen.sv
// Directed bench for async_traffic_gen; expected flits derived by hand from the LFSR sequence from 16'hACE1.
module tb_async_traffic_gen;

  logic        clk;
  logic        reset;
  logic        send;
  logic [15:0] pkt_a, pkt_b, pkt_c;
  logic        busy_a, busy_b, busy_c;
`ifdef TRAFFIC_STATS_EN
  logic [15:0] stall_a, drop_a, stall_b, drop_b, stall_c, drop_c;
`endif

  int n_tests;
  int n_fail;
  int bad;
  bit got_busy;

  async_traffic_gen_if #(.FLIT_W(32)) if_a ();
  async_traffic_gen_if #(.FLIT_W(32)) if_b ();
  async_traffic_gen_if #(.FLIT_W(32)) if_c ();

  async_traffic_gen #(.NODE_ID(3), .NUM_NODES(9), .DEST_BITS(4), .FLIT_W(32),
                      .PKT_FLITS(4), .RATE(256), .SEED(16'hACE1)) u_dut_a (
    .clk(clk), .reset(reset), .send(send), .tx(if_a),
    .pkt_count(pkt_a), .busy(busy_a)
`ifdef TRAFFIC_STATS_EN
    , .stall_count(stall_a), .drop_count(drop_a)
`endif
  );

  async_traffic_gen #(.NODE_ID(0), .NUM_NODES(9), .DEST_BITS(4), .FLIT_W(32),
                      .PKT_FLITS(4), .RATE(0), .SEED(16'hACE1)) u_dut_b (
    .clk(clk), .reset(reset), .send(send), .tx(if_b),
    .pkt_count(pkt_b), .busy(busy_b)
`ifdef TRAFFIC_STATS_EN
    , .stall_count(stall_b), .drop_count(drop_b)
`endif
  );

  // Zero seed must behave exactly like 16'hACE1.
  async_traffic_gen #(.NODE_ID(0), .NUM_NODES(9), .DEST_BITS(4), .FLIT_W(32),
                      .PKT_FLITS(1), .RATE(256), .SEED(16'h0000)) u_dut_c (
    .clk(clk), .reset(reset), .send(send), .tx(if_c),
    .pkt_count(pkt_c), .busy(busy_c)
`ifdef TRAFFIC_STATS_EN
    , .stall_count(stall_c), .drop_count(drop_c)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    reset   = 1'b1;
    send    = 1'b1;
    if_a.tx_ready = 1'b1;
    if_b.tx_ready = 1'b1;
    if_c.tx_ready = 1'b1;

    #2;
    check("rst_a_ctl",  {if_a.tx_valid, if_a.tx_head, if_a.tx_tail, busy_a}, 4'b0000);
    check("rst_a_data", if_a.tx_data, 32'h0);
    check("rst_a_pkt",  pkt_a, 16'h0);
    check("rst_c_ctl",  {if_c.tx_valid, if_c.tx_head, if_c.tx_tail, busy_c}, 4'b0000);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // e0: lfsr ACE1 -> dest 12, invalid for both
    tick();
    check("e0_a_valid", if_a.tx_valid, 1'b0);
    check("e0_c_valid", if_c.tx_valid, 1'b0);
    // e1: lfsr E270 -> dest 2
    tick();
    check("e1_a_ctl",  {if_a.tx_valid, if_a.tx_head, if_a.tx_tail}, 3'b110);
    check("e1_a_head", if_a.tx_data, 32'h0000_0032);
    check("e1_c_ctl",  {if_c.tx_valid, if_c.tx_head, if_c.tx_tail}, 3'b111);
    check("e1_c_head", if_c.tx_data, 32'h0000_0002);
    tick();
    check("e2_a_ctl",  {if_a.tx_valid, if_a.tx_head, if_a.tx_tail}, 3'b100);
    check("e2_a_b1",   if_a.tx_data, 32'h0000_0001);
    check("e2_c_valid", if_c.tx_valid, 1'b0);
    check("e2_c_pkt",  pkt_c, 16'd1);
    tick();
    check("e3_a_b2",   if_a.tx_data, 32'h0000_0002);
    check("e3_a_tail", if_a.tx_tail, 1'b0);
    check("e3_c_ctl",  {if_c.tx_valid, if_c.tx_head, if_c.tx_tail}, 3'b111);
    check("e3_c_head", if_c.tx_data, 32'h0000_0108);
    tick();
    check("e4_a_b3",   if_a.tx_data, 32'h0000_0003);
    check("e4_a_ctl",  {if_a.tx_valid, if_a.tx_head, if_a.tx_tail}, 3'b101);
    check("e4_c_pkt",  pkt_c, 16'd2);
    check("e4_c_valid", if_c.tx_valid, 1'b0);
    tick();
    check("e5_a_idle", {if_a.tx_valid, busy_a}, 2'b00);
    check("e5_a_pkt",  pkt_a, 16'd1);
    // e6: lfsr B313 -> dest 3 == NODE_ID of A, rejected
    tick();
    check("e6_a_self", if_a.tx_valid, 1'b0);
    check("e6_c_head", if_c.tx_data, 32'h0000_0203);
    tick();
    check("e7_a_valid", if_a.tx_valid, 1'b0);
    check("e7_c_pkt",  pkt_c, 16'd3);
    tick();
    check("e8_a_ctl",  {if_a.tx_valid, if_a.tx_head, if_a.tx_tail}, 3'b110);
    check("e8_a_head", if_a.tx_data, 32'h0000_0132);
`ifdef TRAFFIC_STATS_EN
    check("e8_a_drop", drop_a, 16'd3);
`endif

    // Backpressure: head must hold for 10 cycles
    if_a.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_data", if_a.tx_data, 32'h0000_0132);
      check("stall_ctl",  {if_a.tx_valid, if_a.tx_head, if_a.tx_tail}, 3'b110);
    end
`ifdef TRAFFIC_STATS_EN
    check("stall_count", stall_a, 16'd10);
`endif
    if_a.tx_ready = 1'b1;
    tick();
    check("e19_a_b1", if_a.tx_data, 32'h0001_0001);
    tick();
    check("e20_a_b2", if_a.tx_data, 32'h0001_0002);
    tick();
    check("e21_a_b3",  if_a.tx_data, 32'h0001_0003);
    check("e21_a_ctl", {if_a.tx_valid, if_a.tx_head, if_a.tx_tail}, 3'b101);
    tick();
    check("e22_a_valid", if_a.tx_valid, 1'b0);
    check("e22_a_pkt",   pkt_a, 16'd2);
    tick();
    check("e23_a_valid", if_a.tx_valid, 1'b0);
    tick();
    check("e24_a_head", if_a.tx_data, 32'h0000_0235);
    tick();
    check("e25_a_b1", if_a.tx_data, 32'h0002_0001);

    // send drops while the 2nd flit is valid: packet still completes
    send = 1'b0;
    tick();
    check("e26_a_b2", if_a.tx_data, 32'h0002_0002);
    tick();
    check("e27_a_b3",  if_a.tx_data, 32'h0002_0003);
    check("e27_a_ctl", {if_a.tx_valid, if_a.tx_head, if_a.tx_tail}, 3'b101);
    tick();
    check("e28_a_idle", {if_a.tx_valid, busy_a}, 2'b00);
    check("e28_a_pkt",  pkt_a, 16'd3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if_a.tx_valid || busy_a) bad++;
    end
    check("nosend_quiet", bad, 0);

    // Async reset mid-BODY
    send = 1'b1;
    got_busy = 1'b0;
    for (int i = 0; i < 50 && !got_busy; i++) begin
      tick();
      got_busy = busy_a;
    end
    check("rearm_busy", got_busy, 1'b1);
    tick();
    check("midbody_ctl", {if_a.tx_valid, if_a.tx_head}, 2'b10);
    #3;
    reset = 1'b1;
    #1;
    check("arst_a_ctl", {if_a.tx_valid, busy_a}, 2'b00);
    check("arst_a_pkt", pkt_a, 16'h0);
    check("arst_c_pkt", pkt_c, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("r_e0_a_valid", if_a.tx_valid, 1'b0);
    tick();
    check("r_e1_a_head", if_a.tx_data, 32'h0000_0032);
    check("r_e1_c_head", if_c.tx_data, 32'h0000_0002);

    // RATE=0 never injects
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (if_b.tx_valid || busy_b) bad++;
    end
    check("rate0_quiet", bad, 0);
    check("rate0_pkt",   pkt_b, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
